// File: rtl/trivium_stream_ctrl.sv
// Trivium keystream sequencer: load, WARMUP discarded steps, then OUT_W-bit words; first word valid WARMUP+OUT_W+1 cycles after start.
// Backpressure: the core is frozen (core_en=0) when a completed word cannot enter the occupied, unaccepted output register.
module trivium_stream_ctrl #(
  parameter int WARMUP = 1152,
  parameter int OUT_W  = 8,
  parameter int LEN_W  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [79:0]      key,
  input  logic [79:0]      iv,
  input  logic [LEN_W-1:0] len,
  input  logic             abort,
  output logic [79:0]      core_key,
  output logic [79:0]      core_iv,
  output logic             core_load,
  output logic             core_en,
  input  logic             core_z,
  output logic [OUT_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             busy,
  output logic             done
);
  localparam int CW = $clog2(OUT_W + 1);
  localparam int WW = (WARMUP > 1) ? $clog2(WARMUP) : 1;
  localparam int NW = LEN_W + 1;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WARM, S_GEN, S_DRAIN} state_t;

  state_t           state, state_n;
  logic [WW-1:0]    warmcnt;
  logic [CW-1:0]    bitcnt;
  logic [CW-1:0]    lastbits;
  logic [CW-1:0]    tgt;
  logic [NW-1:0]    wcnt;
  logic [OUT_W-1:0] shifter, sh_next;
  logic [NW-1:0]    len_ext, nw_c;
  logic [CW-1:0]    lb_c;
  logic             final_word, word_done, accept, kill;

  // nwords is one bit wider than len so ceil() cannot overflow at the top of the range
  assign len_ext    = {1'b0, len};
  assign nw_c       = (len_ext + NW'(OUT_W - 1)) / NW'(OUT_W);
  assign lb_c       = CW'(len_ext - (nw_c - NW'(1)) * NW'(OUT_W));
  assign final_word = (wcnt == NW'(1));
  assign tgt        = final_word ? lastbits : CW'(OUT_W);
  assign word_done  = (bitcnt == tgt - CW'(1));
  assign accept     = out_valid & out_ready;
  assign kill       = abort & (state != S_IDLE);
  assign busy       = (state != S_IDLE);

  always_comb begin
    sh_next = shifter;
    for (int i = 0; i < OUT_W; i++)
      if (bitcnt == CW'(i)) sh_next[i] = core_z;
  end

  always_comb begin
    state_n   = state;
    core_load = 1'b0;
    core_en   = 1'b0;
    case (state)
      S_IDLE:  if (start && len != '0) state_n = S_LOAD;
      S_LOAD: begin
        core_load = 1'b1;
        state_n   = S_WARM;
      end
      S_WARM: begin
        core_en = 1'b1;
        if (warmcnt == WW'(WARMUP - 1)) state_n = S_GEN;
      end
      S_GEN: begin
        // the bit that completes a word is only taken if the output slot frees this cycle
        core_en = !word_done || !out_valid || out_ready;
        if (core_en && word_done && final_word) state_n = S_DRAIN;
      end
      S_DRAIN: if (accept) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
    if (kill) begin
      state_n   = S_IDLE;
      core_load = 1'b0;
      core_en   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      core_key  <= '0;
      core_iv   <= '0;
      warmcnt   <= '0;
      bitcnt    <= '0;
      lastbits  <= '0;
      wcnt      <= '0;
      shifter   <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      done      <= 1'b0;
    end else begin
      state <= state_n;
      done  <= 1'b0;
      if (accept) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
      case (state)
        S_IDLE: if (start) begin
          core_key <= key;
          core_iv  <= iv;
          wcnt     <= nw_c;
          lastbits <= lb_c;
          bitcnt   <= '0;
          shifter  <= '0;
          if (len == '0) done <= 1'b1;
        end
        S_LOAD: warmcnt <= '0;
        S_WARM: warmcnt <= warmcnt + WW'(1);
        S_GEN: if (core_en) begin
          if (word_done) begin
            out_data  <= sh_next;
            out_valid <= 1'b1;
            out_last  <= final_word;
            shifter   <= '0;
            bitcnt    <= '0;
            wcnt      <= wcnt - NW'(1);
          end else begin
            shifter <= sh_next;
            bitcnt  <= bitcnt + CW'(1);
          end
        end
        S_DRAIN: if (accept) done <= 1'b1;
        default: ;
      endcase
      if (kill) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
        done      <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_trivium_stream_ctrl.sv
// Bench for trivium_stream_ctrl: behavioural Trivium core on the core_* pins, expected
// words from an independent software keystream pushed to a queue at each start.
module tb_trivium_stream_ctrl;
  localparam int WARMUP = 1152;
  localparam int OUT_W  = 8;
  localparam int LEN_W  = 16;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic [79:0]      key = '0;
  logic [79:0]      iv = '0;
  logic [LEN_W-1:0] len = '0;
  logic             abort = 1'b0;
  logic [79:0]      core_key, core_iv;
  logic             core_load, core_en, core_z;
  logic [OUT_W-1:0] out_data;
  logic             out_valid, out_last, busy, done;
  logic             out_ready = 1'b1;

  trivium_stream_ctrl #(.WARMUP(WARMUP), .OUT_W(OUT_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .reset(reset), .start(start), .key(key), .iv(iv), .len(len),
    .abort(abort), .core_key(core_key), .core_iv(core_iv), .core_load(core_load),
    .core_en(core_en), .core_z(core_z), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [287:0] tri_load(input logic [79:0] k, input logic [79:0] v);
    logic [287:0] s;
    s = '0;
    s[79:0] = k;
    s[172:93] = v;
    s[287:285] = 3'b111;
    return s;
  endfunction

  function automatic logic tri_z(input logic [287:0] s);
    return s[65] ^ s[92] ^ s[161] ^ s[176] ^ s[242] ^ s[287];
  endfunction

  function automatic logic [287:0] tri_step(input logic [287:0] s);
    logic t1, t2, t3;
    logic [287:0] n;
    t1 = s[65] ^ s[92] ^ (s[90] & s[91]) ^ s[170];
    t2 = s[161] ^ s[176] ^ (s[174] & s[175]) ^ s[263];
    t3 = s[242] ^ s[287] ^ (s[285] & s[286]) ^ s[68];
    n = s;
    n[92:0] = {s[91:0], t3};
    n[176:93] = {s[175:93], t1};
    n[287:177] = {s[286:177], t2};
    return n;
  endfunction

  // behavioural core driven only by the DUT's core_* outputs
  logic [287:0] cst;
  always @(posedge clk or posedge reset)
    if (reset) cst <= '0;
    else if (core_load) cst <= tri_load(core_key, core_iv);
    else if (core_en) cst <= tri_step(cst);
  assign core_z = tri_z(cst);

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int words, en_cnt, load_cnt, done_cnt, load_cyc, first_ov;
  logic [8:0] exp_q[$];
  logic [8:0] exp_w;
  logic [OUT_W-1:0] last_dat;
  int t0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic gen_expected(input logic [79:0] k, input logic [79:0] v, input int l);
    logic [287:0] s;
    logic [7:0] w;
    int nb;
    s = tri_load(k, v);
    for (int i = 0; i < WARMUP; i++) s = tri_step(s);
    w = '0;
    nb = 0;
    for (int b = 0; b < l; b++) begin
      w[nb] = tri_z(s);
      s = tri_step(s);
      nb++;
      if (nb == OUT_W || b == l - 1) begin
        exp_q.push_back({(b == l - 1), w});
        w = '0;
        nb = 0;
      end
    end
  endtask

  // monitor: sampled on the falling edge, away from the active edge
  always @(negedge clk) begin
    if (core_en) en_cnt++;
    if (core_load) begin
      load_cnt++;
      if (load_cyc < 0) load_cyc = cyc;
    end
    if (done) done_cnt++;
    if (out_valid && first_ov < 0) first_ov = cyc;
    if (out_valid && out_ready) begin
      words++;
      last_dat = out_data;
      if (exp_q.size() == 0) chk("unexpected_word", {out_last, out_data}, 9'h1ff);
      else begin
        exp_w = exp_q.pop_front();
        chk("word", {out_last, out_data}, exp_w);
      end
    end
  end

  task automatic do_start(input logic [79:0] k, input logic [79:0] v, input int l);
    gen_expected(k, v, l);
    words = 0; en_cnt = 0; load_cnt = 0; done_cnt = 0; load_cyc = -1; first_ov = -1;
    @(posedge clk); #1;
    key = k; iv = v; len = LEN_W'(l); start = 1'b1;
    t0 = cyc + 1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && done_cnt == 0; i++) @(posedge clk);
    chk("done_seen", (done_cnt != 0), 1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic wait_words(input int n);
    for (int i = 0; i < 3000 && words < n; i++) @(posedge clk);
    #1;
    chk("words_reached", (words >= n), 1);
  endtask

  localparam logic [79:0] K1 = 80'h80000000000000000000;
  logic [OUT_W-1:0] stab;

  initial begin
    words = 0; en_cnt = 0; load_cnt = 0; done_cnt = 0; load_cyc = -1; first_ov = -1;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_core_key", core_key, 0);
    chk("rst_core_en", core_en, 0);
    chk("rst_core_load", core_load, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // full 4096-bit job with latency checks
    do_start(K1, 80'h0, 4096);
    wait_done(6000);
    chk("a_words", words, 512);
    chk("a_done_cnt", done_cnt, 1);
    chk("a_en_cnt", en_cnt, WARMUP + 4096);
    chk("a_load_cnt", load_cnt, 1);
    chk("a_load_cyc", load_cyc, t0);
    chk("a_first_valid", first_ov, t0 + WARMUP + OUT_W + 1);
    chk("a_queue_empty", exp_q.size(), 0);
    chk("a_busy_idle", busy, 0);

    // short job with a partial final word
    do_start(80'h0123456789abcdef0123, 80'hfedcba98765432100fed, 20);
    wait_done(2000);
    chk("b_words", words, 3);
    chk("b_last_upper", last_dat[7:4], 0);
    chk("b_en_cnt", en_cnt, WARMUP + 20);
    chk("b_queue_empty", exp_q.size(), 0);

    // backpressure mid-stream plus a start pulse while generating
    do_start(K1, 80'h0, 4096);
    wait_words(50);
    out_ready = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    stab = out_data;
    chk("c_valid_held", out_valid, 1);
    repeat (40) @(posedge clk);
    #1;
    chk("c_data_stable", out_data, stab);
    chk("c_valid_stall", out_valid, 1);
    chk("c_core_frozen", core_en, 0);
    out_ready = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    key = 80'h1; len = LEN_W'(8); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(6000);
    chk("c_words", words, 512);
    chk("c_en_cnt", en_cnt, WARMUP + 4096);
    chk("c_done_cnt", done_cnt, 1);
    chk("c_queue_empty", exp_q.size(), 0);

    // abort at word 100, then a clean rerun
    do_start(K1, 80'h0, 4096);
    wait_words(100);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("d_busy_low", busy, 0);
    chk("d_valid_low", out_valid, 0);
    chk("d_core_en_low", core_en, 0);
    repeat (10) @(posedge clk);
    #1;
    chk("d_no_done", done_cnt, 0);
    exp_q.delete();

    do_start(K1, 80'h0, 4096);
    wait_done(6000);
    chk("e_words", words, 512);
    chk("e_done_cnt", done_cnt, 1);
    chk("e_queue_empty", exp_q.size(), 0);

    // zero-length request
    do_start(K1, 80'h0, 0);
    chk("f_done_pulse", done, 1);
    chk("f_busy", busy, 0);
    @(posedge clk); #1;
    chk("f_done_clear", done, 0);
    repeat (5) @(posedge clk);
    #1;
    chk("f_no_load", load_cnt, 0);

    // asynchronous reset during generation
    do_start(K1, 80'h0, 4096);
    wait_words(5);
    reset = 1'b1;
    #1;
    chk("g_out_valid", out_valid, 0);
    chk("g_out_data", out_data, 0);
    chk("g_out_last", out_last, 0);
    chk("g_core_en", core_en, 0);
    chk("g_core_key", core_key, 0);
    chk("g_busy", busy, 0);
    chk("g_done", done, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    exp_q.delete();
    repeat (3) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
